// File: rtl/axi_rd_arbiter_if.sv
// Bundle of cache-side request/beat signals and the shared AXI read channel
// seen by axi_rd_arbiter; master = arbiter, slave = caches + AXI port.
interface axi_rd_arbiter_if #(
    parameter int ID_W  = 4,
    parameter int LEN_W = 8
);
    logic             inst_req;
    logic [31:0]      inst_addr;
    logic [LEN_W-1:0] inst_len;
    logic             inst_cancel;
    logic             inst_addr_ok;
    logic             inst_rvalid;
    logic             inst_rlast;

    logic             data_req;
    logic [31:0]      data_addr;
    logic [LEN_W-1:0] data_len;
    logic             data_addr_ok;
    logic             data_rvalid;
    logic             data_rlast;

    logic [31:0]      rd_rdata;
    logic [LEN_W-1:0] rd_beat;

    logic [ID_W-1:0]  arid;
    logic [31:0]      araddr;
    logic [LEN_W-1:0] arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic             arvalid;
    logic             arready;

    logic [ID_W-1:0]  rid;
    logic [31:0]      rdata;
    logic             rlast;
    logic             rvalid;
    logic             rready;

    modport master (
        input  inst_req, inst_addr, inst_len, inst_cancel,
        input  data_req, data_addr, data_len,
        input  arready, rid, rdata, rlast, rvalid,
        output inst_addr_ok, inst_rvalid, inst_rlast,
        output data_addr_ok, data_rvalid, data_rlast,
        output rd_rdata, rd_beat,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport slave (
        output inst_req, inst_addr, inst_len, inst_cancel,
        output data_req, data_addr, data_len,
        output arready, rid, rdata, rlast, rvalid,
        input  inst_addr_ok, inst_rvalid, inst_rlast,
        input  data_addr_ok, data_rvalid, data_rlast,
        input  rd_rdata, rd_beat,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between ICache and DCache,
// one burst at a time, with silent draining of flushed instruction bursts.
//
//   state  | meaning
//   S_IDLE | no burst; pick owner from pending requests
//   S_AR   | address phase, arvalid held until arready
//   S_R    | data phase, beats routed to owner (or dropped if cancelled)
module axi_rd_arbiter #(
    parameter int ID_W  = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    axi_rd_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t           r_state;
    logic             r_owner;
    logic             r_last_grant;
    logic             r_cancelled;
    logic [LEN_W-1:0] r_beat_cnt;
    logic [31:0]      r_araddr;
    logic [LEN_W-1:0] r_arlen;
    logic [ID_W-1:0]  r_arid;
    logic             r_arvalid;
    logic             r_rready;
    logic             r_inst_addr_ok;
    logic             r_data_addr_ok;

    logic w_inst_req_eff;
    logic w_grant_inst;
    logic w_grant_data;
    logic w_inst_busy;
    logic w_cancel_hit;
    logic w_suppress;
    logic w_beat;
    logic w_unused_rid;

    // A flushed fetch must not start a refill in the same cycle.
    assign w_inst_req_eff = bus.inst_req && !bus.inst_cancel;

    assign w_grant_inst = (r_state == S_IDLE) && w_inst_req_eff &&
                          (!bus.data_req || (r_last_grant == OWN_DATA));
    assign w_grant_data = (r_state == S_IDLE) && bus.data_req &&
                          (!w_inst_req_eff || (r_last_grant == OWN_INST));

    assign w_inst_busy  = (r_state != S_IDLE) && (r_owner == OWN_INST);
    assign w_cancel_hit = w_inst_busy && bus.inst_cancel;

    // Live cancel also hides the beat arriving in the flush cycle itself.
    assign w_suppress = (r_owner == OWN_INST) && (r_cancelled || bus.inst_cancel);
    assign w_beat     = (r_state == S_R) && bus.rvalid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_owner        <= OWN_INST;
            r_last_grant   <= OWN_DATA;
            r_cancelled    <= 1'b0;
            r_beat_cnt     <= '0;
            r_araddr       <= '0;
            r_arlen        <= '0;
            r_arid         <= '0;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_inst_addr_ok <= 1'b0;
            r_data_addr_ok <= 1'b0;
        end else begin
            r_inst_addr_ok <= 1'b0;
            r_data_addr_ok <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_inst || w_grant_data) begin
                        r_state        <= S_AR;
                        r_arvalid      <= 1'b1;
                        r_owner        <= w_grant_data;
                        r_last_grant   <= w_grant_data;
                        r_araddr       <= w_grant_data ? bus.data_addr : bus.inst_addr;
                        r_arlen        <= w_grant_data ? bus.data_len  : bus.inst_len;
                        r_arid         <= ID_W'(w_grant_data);
                        r_inst_addr_ok <= w_grant_inst;
                        r_data_addr_ok <= w_grant_data;
                        r_cancelled    <= 1'b0;
                        r_beat_cnt     <= '0;
                    end
                end
                S_AR: begin
                    if (w_cancel_hit) begin
                        r_cancelled <= 1'b1;
                    end
                    if (bus.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (w_cancel_hit) begin
                        r_cancelled <= 1'b1;
                    end
                    if (bus.rvalid) begin
                        if (bus.rlast) begin
                            r_state     <= S_IDLE;
                            r_rready    <= 1'b0;
                            r_beat_cnt  <= '0;
                            r_cancelled <= 1'b0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inst_addr_ok = r_inst_addr_ok;
    assign bus.data_addr_ok = r_data_addr_ok;

    assign bus.inst_rvalid = w_beat && (r_owner == OWN_INST) && !w_suppress;
    assign bus.inst_rlast  = bus.inst_rvalid && bus.rlast;
    assign bus.data_rvalid = w_beat && (r_owner == OWN_DATA);
    assign bus.data_rlast  = bus.data_rvalid && bus.rlast;

    assign bus.rd_rdata = bus.rdata;
    assign bus.rd_beat  = r_beat_cnt;

    assign bus.arid    = r_arid;
    assign bus.araddr  = r_araddr;
    assign bus.arlen   = r_arlen;
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.arvalid = r_arvalid;
    assign bus.rready  = r_rready;

    // Only one burst is ever outstanding, so the returned ID carries no information.
    assign w_unused_rid = ^bus.rid;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: cycle table for a plain inst burst, then
// hand sequences for arbitration, cancel, backpressure and reset.
module tb_axi_rd_arbiter;

    localparam int ID_W  = 4;
    localparam int LEN_W = 8;
    localparam logic [31:0] I_ADDR = 32'h1FC0_0000;
    localparam logic [31:0] D_ADDR = 32'h8000_1000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.ID_W(ID_W), .LEN_W(LEN_W)) bus ();

    axi_rd_arbiter #(.ID_W(ID_W), .LEN_W(LEN_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          rst_n;
        bit          i_req;
        bit          i_cancel;
        bit          d_req;
        bit          arready;
        bit          rvalid;
        bit          rlast;
        logic [31:0] rdata;
        logic [7:0]  exp;   // {iok, dok, arvalid, rready, irv, irl, drv, drl}
        int          beat;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input bit rst, input bit ireq, input bit icanc,
                                input bit dreq, input bit ardy, input bit rv,
                                input bit rl, input logic [7:0] e, input int beat);
        vec_t v;
        v.rst_n    = rst;
        v.i_req    = ireq;
        v.i_cancel = icanc;
        v.d_req    = dreq;
        v.arready  = ardy;
        v.rvalid   = rv;
        v.rlast    = rl;
        v.rdata    = 32'hA500_0000 + 32'(beat);
        v.exp      = e;
        v.beat     = beat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input bit is_data, input logic [31:0] exp_addr,
                             input int exp_len, input int ar_wait,
                             input int first_supp, input int cancel_beat);
        bit fwd;
        bit last;
        bus.arready = 1'b0;
        for (int w = 0; w < ar_wait; w++) begin
            next_cycle();
            bus.inst_cancel = 1'b0;
            @(negedge clk);
            chk("bp_arvalid", 32'(bus.arvalid), 32'd1);
            chk("bp_addr_ok", 32'({bus.inst_addr_ok, bus.data_addr_ok}), 32'd0);
            chk("bp_araddr", bus.araddr, exp_addr);
            chk("bp_arlen", 32'(bus.arlen), 32'(exp_len));
            chk("bp_rready", 32'(bus.rready), 32'd0);
        end
        bus.arready = 1'b1;
        next_cycle();
        bus.arready     = 1'b0;
        bus.inst_cancel = 1'b0;
        for (int b = 0; b <= exp_len; b++) begin
            last            = (b == exp_len);
            bus.rvalid      = 1'b1;
            bus.rlast       = last;
            bus.rdata       = 32'hC0DE_0000 + 32'(b);
            bus.inst_cancel = (b == cancel_beat);
            fwd             = is_data || (b < first_supp);
            @(negedge clk);
            chk("beat_rready", 32'(bus.rready), 32'd1);
            chk("beat_inst_rvalid", 32'(bus.inst_rvalid), 32'(!is_data && fwd));
            chk("beat_inst_rlast", 32'(bus.inst_rlast), 32'(!is_data && fwd && last));
            chk("beat_data_rvalid", 32'(bus.data_rvalid), 32'(is_data));
            chk("beat_data_rlast", 32'(bus.data_rlast), 32'(is_data && last));
            chk("beat_index", 32'(bus.rd_beat), 32'(b));
            if (fwd) chk("beat_rdata", bus.rd_rdata, 32'hC0DE_0000 + 32'(b));
            next_cycle();
        end
        bus.rvalid      = 1'b0;
        bus.rlast       = 1'b0;
        bus.inst_cancel = 1'b0;
        @(negedge clk);
        chk("post_rready", 32'(bus.rready), 32'd0);
        chk("post_arvalid", 32'(bus.arvalid), 32'd0);
        chk("post_beat", 32'(bus.rd_beat), 32'd0);
    endtask

    initial begin
        bus.inst_req    = 1'b0;
        bus.inst_addr   = I_ADDR;
        bus.inst_len    = 8'd7;
        bus.inst_cancel = 1'b0;
        bus.data_req    = 1'b0;
        bus.data_addr   = D_ADDR;
        bus.data_len    = 8'd0;
        bus.arready     = 1'b0;
        bus.rid         = '0;
        bus.rdata       = '0;
        bus.rlast       = 1'b0;
        bus.rvalid      = 1'b0;

        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 8'b0000_0000, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0, 8'b0000_0000, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0, 0, 0, 8'b1010_0000, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 8'b0010_0000, 0);
        vecs[4]  = mk(1, 0, 0, 0, 1, 0, 0, 8'b0010_0000, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 1, 0, 8'b0001_1000, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 1, 0, 8'b0001_1000, 1);
        vecs[7]  = mk(1, 0, 0, 0, 0, 1, 0, 8'b0001_1000, 2);
        vecs[8]  = mk(1, 0, 0, 0, 0, 1, 0, 8'b0001_1000, 3);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 8'b0001_0000, 4);
        vecs[10] = mk(1, 0, 0, 0, 0, 1, 0, 8'b0001_1000, 4);
        vecs[11] = mk(1, 0, 0, 0, 0, 1, 0, 8'b0001_1000, 5);
        vecs[12] = mk(1, 0, 0, 0, 0, 1, 0, 8'b0001_1000, 6);
        vecs[13] = mk(1, 0, 0, 0, 0, 1, 1, 8'b0001_1100, 7);
        vecs[14] = mk(1, 0, 0, 0, 0, 1, 1, 8'b0000_0000, 0);
        vecs[15] = mk(1, 1, 1, 0, 0, 0, 0, 8'b0000_0000, 0);
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, 8'b0000_0000, 0);

        repeat (2) @(posedge clk);
        #1;

        // Table: reset, single 8-beat inst burst with a gap, stray beat in IDLE,
        // and a request masked by a same-cycle cancel.
        for (int k = 0; k < 17; k++) begin
            resetn          = vecs[k].rst_n;
            bus.inst_req    = vecs[k].i_req;
            bus.inst_cancel = vecs[k].i_cancel;
            bus.data_req    = vecs[k].d_req;
            bus.arready     = vecs[k].arready;
            bus.rvalid      = vecs[k].rvalid;
            bus.rlast       = vecs[k].rlast;
            bus.rdata       = vecs[k].rdata;
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", k),
                32'({bus.inst_addr_ok, bus.data_addr_ok, bus.arvalid, bus.rready,
                     bus.inst_rvalid, bus.inst_rlast, bus.data_rvalid, bus.data_rlast}),
                32'(vecs[k].exp));
            chk($sformatf("vec%0d_beat", k), 32'(bus.rd_beat), 32'(vecs[k].beat));
            if (vecs[k].rvalid && vecs[k].exp[3])
                chk($sformatf("vec%0d_rdata", k), bus.rd_rdata, vecs[k].rdata);
            if (vecs[k].exp[5]) begin
                chk($sformatf("vec%0d_araddr", k), bus.araddr, I_ADDR);
                chk($sformatf("vec%0d_arlen", k), 32'(bus.arlen), 32'd7);
                chk($sformatf("vec%0d_arid", k), 32'(bus.arid), 32'd0);
            end
            if (!vecs[k].rst_n) begin
                chk("reset_araddr", bus.araddr, 32'd0);
                chk("reset_arlen", 32'(bus.arlen), 32'd0);
                chk("reset_arid", 32'(bus.arid), 32'd0);
                chk("arsize_const", 32'(bus.arsize), 32'd2);
                chk("arburst_const", 32'(bus.arburst), 32'd1);
            end
            next_cycle();
        end

        // Tie from reset: inst first, then data wins the repeated tie, then inst again.
        resetn = 1'b0;
        next_cycle();
        resetn        = 1'b1;
        bus.inst_len  = 8'd1;
        bus.data_len  = 8'd0;
        bus.inst_req  = 1'b1;
        bus.data_req  = 1'b1;
        @(negedge clk);
        chk("tie1_no_early_grant", 32'({bus.inst_addr_ok, bus.data_addr_ok}), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("tie1_inst_ok", 32'(bus.inst_addr_ok), 32'd1);
        chk("tie1_data_ok", 32'(bus.data_addr_ok), 32'd0);
        chk("tie1_arid", 32'(bus.arid), 32'd0);
        chk("tie1_araddr", bus.araddr, I_ADDR);
        chk("tie1_arlen", 32'(bus.arlen), 32'd1);
        bus.inst_req = 1'b0;
        bus.inst_len = 8'd7;
        run_burst(1'b0, I_ADDR, 1, 0, 99, -1);
        bus.inst_req = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("tie2_data_ok", 32'(bus.data_addr_ok), 32'd1);
        chk("tie2_inst_ok", 32'(bus.inst_addr_ok), 32'd0);
        chk("tie2_arid", 32'(bus.arid), 32'd1);
        chk("tie2_araddr", bus.araddr, D_ADDR);
        chk("tie2_arlen", 32'(bus.arlen), 32'd0);
        bus.data_req = 1'b0;
        // inst_cancel during a data burst must not drop the beat.
        run_burst(1'b1, D_ADDR, 0, 1, 99, 0);
        bus.data_req = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("tie3_inst_ok", 32'(bus.inst_addr_ok), 32'd1);
        chk("tie3_data_ok", 32'(bus.data_addr_ok), 32'd0);
        chk("tie3_arlen", 32'(bus.arlen), 32'd7);
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;

        // Cancel pulse at beat 3: beats 0..2 forwarded, 3..7 drained.
        run_burst(1'b0, I_ADDR, 7, 0, 3, 3);

        // Cancel in the grant cycle, data request pending behind it.
        bus.inst_req = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("arcancel_inst_ok", 32'(bus.inst_addr_ok), 32'd1);
        bus.inst_req    = 1'b0;
        bus.data_req    = 1'b1;
        bus.inst_cancel = 1'b1;
        run_burst(1'b0, I_ADDR, 7, 2, 0, -1);
        next_cycle();
        @(negedge clk);
        chk("arcancel_data_ok", 32'(bus.data_addr_ok), 32'd1);
        chk("arcancel_arid", 32'(bus.arid), 32'd1);

        // Backpressure: arready held low for 10 cycles while data_req stays high.
        run_burst(1'b1, D_ADDR, 0, 10, 99, -1);
        bus.data_req = 1'b0;

        // Reset in the middle of a burst.
        bus.inst_req = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rst_mid_grant", 32'(bus.inst_addr_ok), 32'd1);
        bus.inst_req = 1'b0;
        bus.arready  = 1'b1;
        next_cycle();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h1234_5678;
        @(negedge clk);
        chk("rst_mid_beat", 32'(bus.inst_rvalid), 32'd1);
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_mid_rready", 32'(bus.rready), 32'd0);
        chk("rst_mid_arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst_mid_rvalid", 32'(bus.inst_rvalid), 32'd0);
        chk("rst_mid_beatcnt", 32'(bus.rd_beat), 32'd0);
        bus.rvalid   = 1'b0;
        bus.inst_req = 1'b1;
        bus.data_req = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rst_tie_inst_ok", 32'(bus.inst_addr_ok), 32'd1);
        chk("rst_tie_data_ok", 32'(bus.data_addr_ok), 32'd0);
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
